// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults (H_TOTAL=800, V_TOTAL=525), colour FSM state encodings, colour type
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [0:0] STABLE = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
  typedef logic [2:0] colour_t;
endpackage

// File: rtl/vga_sync.sv
// vga_sync: 25 MHz tick + h/v counters; in clk,rst; out h_count,v_count, comb hsync,vsync,video_on,frame_start
module vga_sync #(
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BACK
) (
  input logic clk,
  input logic rst,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic frame_start
);
  localparam int h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int hs_start = H_DISPLAY + H_FRONT;
  localparam int vs_start = V_DISPLAY + V_FRONT;
  logic tick;
  logic h_end, v_end;
  assign h_end = h_count == 10'(h_total - 1);
  assign v_end = v_count == 10'(v_total - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      tick <= !tick;
      if (tick) begin
        h_count <= h_end ? '0 : h_count + 10'd1;
        if (h_end) v_count <= v_end ? '0 : v_count + 10'd1;
      end
    end
  end
  assign hsync = !(h_count >= 10'(hs_start) && h_count < 10'(hs_start + H_SYNC));
  assign vsync = !(v_count >= 10'(vs_start) && v_count < 10'(vs_start + V_SYNC));
  assign video_on = h_count < 10'(H_DISPLAY) && v_count < 10'(V_DISPLAY);
  assign frame_start = tick && h_count == '0 && v_count == '0;
endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA top; in CLK_50MHZ,reset,sw[2:0]; out registered hsync,vsync,rgb,video_on,pixel_x,pixel_y,frame_tick
module vga_ctrl #(
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BACK = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT = vga_pkg::V_FRONT,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BACK = vga_pkg::V_BACK
) (
  input logic CLK_50MHZ,
  input logic reset,
  input logic [2:0] sw,
  output logic hsync,
  output logic vsync,
  output logic [2:0] rgb,
  output logic video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic frame_tick
);
  import vga_pkg::*;
  logic [9:0] h_count, v_count;
  logic hs, vs, vid, fs;
  logic [0:0] state, state_n;
  colour_t sw_meta, sw_sync, cand, cand_n, colour, colour_n;
  logic armed, armed_n;
  vga_sync #(
    .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_sync (
    .clk(CLK_50MHZ),
    .rst(reset),
    .h_count(h_count),
    .v_count(v_count),
    .hsync(hs),
    .vsync(vs),
    .video_on(vid),
    .frame_start(fs)
  );
  always_comb begin
    state_n = state;
    cand_n = cand;
    colour_n = colour;
    armed_n = armed;
    if (state == STABLE) begin
      if (sw_sync != colour) begin
        state_n = PENDING;
        cand_n = sw_sync;
        armed_n = fs;
      end
    end else if (sw_sync == colour) begin
      state_n = STABLE;
    end else if (sw_sync != cand) begin
      cand_n = sw_sync;
      armed_n = fs;
    end else if (fs) begin
      if (armed) begin
        colour_n = cand;
        state_n = STABLE;
      end
      armed_n = 1'b1;
    end
  end
  always_ff @(posedge CLK_50MHZ) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      state <= STABLE;
      cand <= '0;
      colour <= '0;
      armed <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb <= 3'b000;
      video_on <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
      frame_tick <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      state <= state_n;
      cand <= cand_n;
      colour <= colour_n;
      armed <= armed_n;
      hsync <= hs;
      vsync <= vs;
      rgb <= vid ? colour : 3'b000;
      video_on <= vid;
      pixel_x <= h_count;
      pixel_y <= v_count;
      frame_tick <= fs;
    end
  end
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: scoreboard bench for vga_ctrl against an arithmetic reference model
module tb_vga_ctrl;
  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 8, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FR = 2 * HT * VT;
  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
    logic ft;
    logic [2:0] rgb;
    logic [9:0] px;
    logic [9:0] py;
  } out_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] sw = 3'b000;
  logic hsync, vsync, video_on, frame_tick;
  logic [2:0] rgb;
  logic [9:0] pixel_x, pixel_y;
  logic hsync_f, vsync_f, video_on_f, frame_tick_f;
  logic [2:0] rgb_f;
  logic [9:0] pixel_x_f, pixel_y_f;
  int errors = 0;
  int checks = 0;
  out_t exp_q[$];
  vga_ctrl #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .CLK_50MHZ(clk), .reset(reset), .sw(sw),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_tick(frame_tick)
  );
  vga_ctrl dut_full (
    .CLK_50MHZ(clk), .reset(reset), .sw(sw),
    .hsync(hsync_f), .vsync(vsync_f), .rgb(rgb_f), .video_on(video_on_f),
    .pixel_x(pixel_x_f), .pixel_y(pixel_y_f), .frame_tick(frame_tick_f)
  );
  initial forever #10 clk = ~clk;
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  // Reference: after n released edges the pixel index is n/2; a colour commits at a
  // frame start if synced sw held one value since the previous frame start.
  initial begin
    out_t e;
    int n, p, h, v;
    bit fs, run_ok;
    logic [2:0] m1, m2, com, run_val;
    n = 0; m1 = 0; m2 = 0; com = 0; run_val = 0; run_ok = 0;
    forever begin
      @(posedge clk);
      e = '0;
      if (reset) begin
        e.hs = 1'b1;
        e.vs = 1'b1;
        n = 0; m1 = 0; m2 = 0; com = 0; run_val = 0; run_ok = 0;
      end else begin
        p = n / 2;
        h = p % HT;
        v = (p / HT) % VT;
        fs = (n % 2 == 1) && h == 0 && v == 0;
        e.hs = !(h >= HD + HF && h < HD + HF + HS);
        e.vs = !(v >= VD + VF && v < VD + VF + VS);
        e.vid = h < HD && v < VD;
        e.rgb = e.vid ? com : 3'b000;
        e.px = 10'(h);
        e.py = 10'(v);
        e.ft = fs;
        if (m2 != run_val) run_ok = 0;
        if (fs) begin
          if (run_ok && m2 != com) com = m2;
          run_val = m2;
          run_ok = 1;
        end
        m2 = m1;
        m1 = sw;
        n++;
      end
      exp_q.push_back(e);
    end
  end
  initial begin
    out_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{hsync, vsync, video_on, frame_tick, rgb, pixel_x, pixel_y};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got hs=%b vs=%b vid=%b ft=%b rgb=%b x=%0d y=%0d want hs=%b vs=%b vid=%b ft=%b rgb=%b x=%0d y=%0d",
                   $time, a.hs, a.vs, a.vid, a.ft, a.rgb, a.px, a.py, e.hs, e.vs, e.vid, e.ft, e.rgb, e.px, e.py);
        end
      end
    end
  end
  initial begin
    int hs_lo, vs_lo, hs_lo_f, vs_lo_f, max_x;
    hs_lo = 0; vs_lo = 0; hs_lo_f = 0; vs_lo_f = 0; max_x = 0;
    repeat (10) @(negedge clk);
    chk("reset_sync", {hsync, vsync}, 2'b11);
    chk("reset_rgb", {rgb, video_on, frame_tick}, 0);
    chk("reset_xy", {pixel_x, pixel_y}, 0);
    chk("reset_full", {hsync_f, vsync_f, rgb_f, pixel_x_f, pixel_y_f}, {2'b11, 23'd0});
    reset = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      hs_lo_f += int'(!hsync_f);
      vs_lo_f += int'(!vsync_f);
      if (int'(pixel_x_f) > max_x) max_x = int'(pixel_x_f);
      if (i < FR) begin
        hs_lo += int'(!hsync);
        vs_lo += int'(!vsync);
      end
    end
    chk("full_hsync_low_per_line", hs_lo_f, 192);
    chk("full_vsync_low_line0", vs_lo_f, 0);
    chk("full_max_pixel_x", max_x, 799);
    chk("small_hsync_low_per_frame", hs_lo, 2 * HS * VT);
    chk("small_vsync_low_per_frame", vs_lo, 2 * VS * HT);
    repeat (37) @(negedge clk);
    sw = 3'b100;
    repeat (3 * FR) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      sw = k[0] ? 3'b100 : 3'b010;
      repeat (FR / 3) @(negedge clk);
    end
    sw = 3'b001;
    repeat (3 * FR) @(negedge clk);
    repeat ($urandom_range(FR - 1, 0)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (FR / 2) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      sw = 3'($urandom);
      repeat ($urandom_range(1500, 20)) @(negedge clk);
      if ($urandom_range(7, 0) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(3, 1)) @(negedge clk);
        reset = 1'b0;
      end
    end
    sw = 3'b111;
    repeat (3 * FR) @(negedge clk);
    chk("scoreboard_active", int'(checks > 10000), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
